cp0_exc_unit: RTL and testbench



---
 rtl/cp0_exc_unit_pkg.sv | 28 ++
 rtl/cp0_exc_unit.sv | 115 +++++++++++
 tb/tb_cp0_exc_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_unit_pkg.sv
// rtl/cp0_exc_unit_pkg.sv - CP0 register numbers, exception codes and field positions
package cp0_exc_unit_pkg;

  // CP0 register numbers (rd field of mfc0/mtc0)
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Exception codes carried in Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Field positions inside SR and Cause
  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int EC_HI   = 6;
  localparam int EC_LO   = 2;

endpackage

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 exception/interrupt unit (SR, Cause, EPC, PrID)
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h2017_1205
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exccode_m,
  input  logic [5:0]  hwint,
  input  logic        eret_m,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [31:0] epc,
  output logic        intreq,
  output logic [31:0] exc_pc
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exccode;
  logic [29:0] epc_q;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] pc_al;
  logic [31:0] epc_next;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic        unused_pc;

  // PC is word aligned; the low two bits never reach EPC
  assign unused_pc = ^pc_m[1:0];

  assign int_pend = (|(hwint & im)) & ie & ~exl;
  assign exc_pend = (exccode_m != 5'd0) & ~exl;
  assign intreq   = int_pend | exc_pend;
  assign exc_pc   = HANDLER_ADDR;
  assign epc      = {epc_q, 2'b00};

  // Restart address: a delay-slot instruction resumes at its branch (wraps modulo 2^32)
  always_comb begin
    pc_al    = {pc_m[31:2], 2'b00};
    epc_next = bd_m ? (pc_al - 32'd4) : pc_al;
  end

  // Pack SR and Cause for reads; unused bits read zero
  always_comb begin
    sr_val                 = '0;
    sr_val[IM_HI:IM_LO]    = im;
    sr_val[EXL_BIT]        = exl;
    sr_val[IE_BIT]         = ie;
    cause_val              = '0;
    cause_val[BD_BIT]      = bd;
    cause_val[IP_HI:IP_LO] = ip;
    cause_val[EC_HI:EC_LO] = exccode;
  end

  // mfc0 read mux, shows pre-write register values
  always_comb begin
    dout = '0;
    case (addr)
      CP0_SR:    dout = sr_val;
      CP0_CAUSE: dout = cause_val;
      CP0_EPC:   dout = {epc_q, 2'b00};
      CP0_PRID:  dout = PRID;
      default:   dout = '0;
    endcase
  end

  // Register update: exception entry beats mtc0 and eret; IP samples hwint every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      ip      <= '0;
      exccode <= '0;
      epc_q   <= '0;
    end else begin
      ip <= hwint;
      if (intreq) begin
        exl     <= 1'b1;
        exccode <= int_pend ? EXC_INT : exccode_m;
        bd      <= bd_m;
        epc_q   <= epc_next[31:2];
      end else begin
        if (eret_m) begin
          exl <= 1'b0;
        end
        if (we) begin
          case (addr)
            CP0_SR: begin
              im  <= din[IM_HI:IM_LO];
              exl <= din[EXL_BIT];
              ie  <= din[IE_BIT];
            end
            CP0_EPC: epc_q <= din[31:2];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - directed self-checking bench for cp0_exc_unit
module tb_cp0_exc_unit;
  import cp0_exc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exccode_m;
  logic [5:0]  hwint;
  logic        eret_m;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] epc;
  logic        intreq;
  logic [31:0] exc_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_exc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .pc_m      (pc_m),
    .bd_m      (bd_m),
    .exccode_m (exccode_m),
    .hwint     (hwint),
    .eret_m    (eret_m),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .epc       (epc),
    .intreq    (intreq),
    .exc_pc    (exc_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  initial begin
    reset = 1'b1; pc_m = '0; bd_m = 1'b0; exccode_m = '0; hwint = '0;
    eret_m = 1'b0; we = 1'b0; addr = '0; din = '0;
    tick;
    reset = 1'b0;
    #1;
    check("rst_intreq", {31'b0, intreq}, 32'h0);
    rd(CP0_SR,    "rst_sr",    32'h0);
    rd(CP0_CAUSE, "rst_cause", 32'h0);
    rd(CP0_EPC,   "rst_epc",   32'h0);
    check("exc_pc", exc_pc, 32'h0000_4180);

    // 1: enable IM[10]+IE, then interrupt on hwint[0]
    we = 1'b1; addr = CP0_SR; din = 32'h0000_0401;
    tick;
    we = 1'b0;
    rd(CP0_SR, "t1_sr_wr", 32'h0000_0401);
    hwint = 6'b000001; pc_m = 32'h3010; bd_m = 1'b0;
    #1;
    check("t1_intreq", {31'b0, intreq}, 32'h1);
    tick;
    check("t1_epc", epc, 32'h3010);
    check("t1_intreq_drop", {31'b0, intreq}, 32'h0);
    rd(CP0_SR,    "t1_sr_exl", 32'h0000_0403);
    rd(CP0_CAUSE, "t1_cause",  32'h0000_0400);

    // 3: EXL masks everything; eret re-enables and pending hwint fires
    exccode_m = EXC_ADEL;
    #1;
    check("t3_masked", {31'b0, intreq}, 32'h0);
    exccode_m = 5'd0; eret_m = 1'b1;
    tick;
    eret_m = 1'b0;
    rd(CP0_SR, "t3_sr_eret", 32'h0000_0401);
    check("t3_refire", {31'b0, intreq}, 32'h1);
    tick;
    hwint = 6'b0; eret_m = 1'b1;
    tick;
    eret_m = 1'b0;

    // 2: overflow in delay slot
    exccode_m = EXC_OV; pc_m = 32'h3024; bd_m = 1'b1;
    #1;
    check("t2_intreq", {31'b0, intreq}, 32'h1);
    tick;
    exccode_m = 5'd0; bd_m = 1'b0;
    check("t2_epc", epc, 32'h3020);
    rd(CP0_CAUSE, "t2_cause", 32'h8000_0030);
    eret_m = 1'b1;
    tick;
    eret_m = 1'b0;

    // 4: mtc0 EPC suppressed by interrupt, then allowed
    we = 1'b1; addr = CP0_EPC; din = 32'h5555_5557; hwint = 6'b000001; pc_m = 32'h4000;
    #1;
    check("t4_intreq", {31'b0, intreq}, 32'h1);
    tick;
    we = 1'b0; hwint = 6'b0;
    check("t4_suppr", epc, 32'h4000);
    eret_m = 1'b1;
    tick;
    eret_m = 1'b0;
    we = 1'b1; addr = CP0_EPC; din = 32'h5555_5557;
    tick;
    we = 1'b0;
    check("t4_epc_wr", epc, 32'h5555_5554);
    we = 1'b1; din = 32'h0000_1234; eret_m = 1'b1;
    #1;
    check("t4_epc_old", epc, 32'h5555_5554);
    tick;
    we = 1'b0; eret_m = 1'b0;
    check("t4_epc_eret_wr", epc, 32'h0000_1234);

    // 5: reads
    rd(CP0_PRID, "t5_prid", 32'h2017_1205);
    hwint = 6'b100000;
    rd(CP0_CAUSE, "t5_ip_pre", 32'h0);
    tick;
    rd(CP0_CAUSE, "t5_ip_post", 32'h0000_8000);
    rd(5'd7, "t5_unk", 32'h0);
    we = 1'b1; addr = CP0_CAUSE; din = 32'hFFFF_FFFF;
    tick;
    we = 1'b0;
    rd(CP0_CAUSE, "t5_cause_ro", 32'h0000_8000);

    // wrap: pc 0 in delay slot
    pc_m = 32'h0; bd_m = 1'b1; exccode_m = EXC_ADES;
    #1;
    check("wrap_intreq", {31'b0, intreq}, 32'h1);
    tick;
    exccode_m = 5'd0; bd_m = 1'b0;
    check("wrap_epc", epc, 32'hFFFF_FFFC);
    rd(CP0_CAUSE, "wrap_cause", 32'h8000_8014);

    // 6: reset mid-handler
    reset = 1'b1;
    tick;
    reset = 1'b0; hwint = 6'b111111;
    #1;
    rd(CP0_SR,    "t6_sr",    32'h0);
    rd(CP0_CAUSE, "t6_cause", 32'h0);
    check("t6_epc", epc, 32'h0);
    check("t6_intreq", {31'b0, intreq}, 32'h0);
    tick;
    check("t6_intreq_hold", {31'b0, intreq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
